// File: rtl/window_seq_ctrl.sv
// Window sequencing controller for a 3x3 sliding window fed by two chained
// line buffers. It walks the frame raster, enables line-buffer shifts on
// accepted pixels, and flags each position where the taps hold a full window.
module window_seq_ctrl #(
    parameter int MAX_WIDTH  = 128,
    parameter int MAX_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_width,
    input  logic [31:0] cfg_height,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] lb_curr_width,
    output logic        lb_data_valid,
    output logic        win_valid,
    output logic [31:0] win_row,
    output logic [31:0] win_col,
    output logic        busy,
    output logic        done,
    output logic        err_cfg
);

    localparam int CW = (MAX_WIDTH  > 1) ? $clog2(MAX_WIDTH)  : 1;
    localparam int RW = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;
    localparam logic [31:0] MAXW = 32'(MAX_WIDTH);
    localparam logic [31:0] MAXH = 32'(MAX_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e          state_q;
    logic [31:0]     width_q;
    logic [31:0]     height_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic            win_valid_q;
    logic [CW-1:0]   win_col_q;
    logic [RW-1:0]   win_row_q;
    logic            err_cfg_q;

    logic            accept;
    logic            cfg_ok;
    logic            col_last;
    logic            row_last;
    logic            win_full;

    assign in_ready      = (state_q == RUN);
    assign accept        = in_valid & in_ready;
    assign lb_data_valid = accept;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err_cfg       = err_cfg_q;
    assign lb_curr_width = width_q;
    assign win_valid     = win_valid_q;
    assign win_col       = 32'(win_col_q);
    assign win_row       = 32'(win_row_q);

    assign cfg_ok   = (cfg_width  >= 32'd3) && (cfg_width  <= MAXW) &&
                      (cfg_height >= 32'd3) && (cfg_height <= MAXH);
    assign col_last = (32'(col_q) == (width_q  - 32'd1));
    assign row_last = (32'(row_q) == (height_q - 32'd1));
    // Two full rows and two full columns already shifted in means the taps
    // hold a complete window anchored two pixels up-left of the current one.
    assign win_full = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Frame FSM: config latch, raster counters and registered window/err flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            err_cfg_q   <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            err_cfg_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            width_q  <= cfg_width;
                            height_q <= cfg_height;
                            col_q    <= '0;
                            row_q    <= '0;
                            state_q  <= RUN;
                        end else begin
                            err_cfg_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (win_full) begin
                            win_valid_q <= 1'b1;
                            win_row_q   <= row_q - RW'(2);
                            win_col_q   <= col_q - CW'(2);
                        end
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                state_q <= DONE;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
